i2s_master_tx: RTL and testbench
================================

Name: i2s_master_tx

Overview:
I2S bus-master transmitter for the audio path. It generates BCLK and LRCK from the system clock and serializes stereo PCM samples MSB-first in standard I2S format (one-BCLK delay after the LRCK edge). It is the counterpart of the existing slave-mode send/receive logic, for configurations where the FPGA, not the ES8388, drives the audio clocks. User logic feeds it through a one-entry valid/ready sample buffer.

Parameters:
CLK_DIV, 8, clk cycles per BCLK half-period (>=1); 50 MHz/16 = 3.125 MHz BCLK
WL, 24, audio word length in bits (1..SLOT-1)
SLOT, 32, BCLK periods per channel slot; frame = 2*SLOT BCLKs

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  run request; sampled every clk
s_valid  in  1  stereo sample valid
s_ready  out  1  holding register empty
s_data_l  in  WL  left sample, two's complement
s_data_r  in  WL  right sample, two's complement
i2s_bclk  out  1  bit clock, registered
i2s_lrc  out  1  word select: 0 = left, 1 = right
i2s_dout  out  1  serial data, changes on BCLK falling edge
tx_done  out  1  one-clk pulse when a full stereo frame has been shifted out
underrun  out  1  one-clk pulse when a frame starts with an empty buffer

Behaviour:
- Reset (rst_n=0 at a clk edge): i2s_bclk=0, i2s_lrc=0, i2s_dout=0, tx_done=0, underrun=0. Holding register is emptied, so s_ready=1. FSM goes to IDLE and all counters are cleared. Reset applied mid-frame takes effect on that edge, with no frame completion.
- Divider: div_cnt runs 0..CLK_DIV-1 in RUN. On the wrap, i2s_bclk toggles. fall_stb is asserted in the cycle bclk goes 1->0; rise_stb in the cycle it goes 0->1.
- Buffer: s_data is accepted when s_valid && s_ready. s_ready drops the cycle after acceptance. It returns high the cycle after the buffer is transferred to the shift registers. An accept and a transfer in the same cycle are not possible, because s_ready=0 while the buffer is full.
- FSM IDLE:
  - bclk, lrc and dout are held at 0.
  - enable=1 moves to RUN with bit_cnt=0, lrc=0, div_cnt=0.
  - A frame-start load happens on entry. That load is treated like a fall_stb at bit_cnt=0 for buffer transfer and underrun.
- FSM RUN:
  - bit_cnt counts 0..2*SLOT-1. It increments on each fall_stb and wraps to 0.
  - lrc = bit_cnt >= SLOT, updated on fall_stb.
  - Within a slot at position p = bit_cnt mod SLOT: dout = 0 at p=0, dout = word[WL-p] for p=1..WL, dout = 0 for p>WL.
- Frame start (fall_stb with wrap to bit_cnt=0, or RUN entry):
  - If the buffer is full, load L and R into the shift registers and mark the buffer empty.
  - Otherwise load zeros and pulse underrun.
- tx_done pulses in the same cycle as a frame-start wrap, for the frame just completed. It does not pulse on RUN entry.
- enable=0 during RUN: the current frame completes. At the next wrap to bit_cnt=0 the FSM goes to IDLE: bclk=0, lrc=0, dout=0 and tx_done pulses, with no load and no underrun. The buffer contents are retained.
- Timing: bclk period = 2*CLK_DIV clk. Frame = 4*SLOT*CLK_DIV clk.

Decomposition:
- Package es_audio_pkg holds:
  - WL_DEF = 24
  - SLOT_DEF = 32
  - FSM state encoding (IDLE, RUN)
  - bit_cnt width function clog2(2*SLOT)
- Sub-module i2s_clk_gen (divider plus bclk register plus fall_stb/rise_stb) is natural, and is reused by a future i2s_master_rx.

Test Plan:
1. Reset -> all outputs 0 and s_ready=1. Then hold rst_n=0 for 3 clk with enable=1 -> bclk stays 0.
2. CLK_DIV=2. Push L=24'hA5A5A5, R=24'h5A5A5A, then enable=1.
   - bclk period is 4 clk.
   - lrc is low for 32 bclk, then high for 32.
   - Each slot shows dout=0, then the 24 data bits MSB-first, then 7 zeros.
   - tx_done pulses after 256 clk.
3. enable=1 with no s_valid -> dout is all 0 and underrun pulses once per frame (every 256 clk at CLK_DIV=2). No tx_done is missing.
4. Back-pressure: hold s_valid with samples 24'h000001 and then 24'h800000.
   - The second sample is accepted only after the first frame-start transfer.
   - s_ready stays low between the two.
   - The frames carry the samples in order.
5. Deassert enable at bit_cnt=40 -> the frame finishes, tx_done pulses, the FSM goes IDLE, and bclk/lrc/dout are 0 with no underrun.
6. Assert rst_n=0 at bit_cnt=10 -> outputs are 0 on the next edge. Re-enable -> a clean frame starts at lrc=0 with no tx_done.

Source files
------------

// File: rtl/es_audio_pkg.sv
// Shared audio-path definitions: default word/slot sizes, transmitter state
// encoding and counter-width helpers.
package es_audio_pkg;

  localparam int unsigned WL_DEF   = 24;
  localparam int unsigned SLOT_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // Ceiling log2 usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter spanning one stereo frame of 2*slot bit clocks.
  function automatic int unsigned bit_cnt_w(input int unsigned slot);
    return (clog2(2 * slot) < 1) ? 1 : clog2(2 * slot);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator: divides clk by 2*CLK_DIV while run is high and
// flags the cycle on which each BCLK edge is produced.
module i2s_clk_gen
  import es_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic fall_stb_c,
  output logic rise_stb_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap_c;

  assign wrap_c     = run && (div_cnt == DIV_LAST);
  assign fall_stb_c = wrap_c && bclk;
  assign rise_stb_c = wrap_c && !bclk;

  // Leaving run parks the divider so the next start begins on a fresh low phase.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap_c) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: drives BCLK/LRCK and shifts stereo samples out
// MSB-first, one BCLK after each LRCK edge, from a one-entry sample buffer.
module i2s_master_tx
  import es_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned WL      = WL_DEF,
  parameter int unsigned SLOT    = SLOT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [WL-1:0] s_data_l,
  input  logic [WL-1:0] s_data_r,
  output logic          i2s_bclk,
  output logic          i2s_lrc,
  output logic          i2s_dout,
  output logic          tx_done,
  output logic          underrun
);

  localparam int unsigned BW = bit_cnt_w(SLOT);
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
  localparam logic [BW-1:0] WL_B     = BW'(WL);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d, pos_c;
  logic [WL-1:0] buf_l, buf_r;
  logic [WL-1:0] sh_l, sh_r, sh_l_d, sh_r_d;
  logic          lrc_d, dout_d, tx_done_d, underrun_d;
  logic          frame_start_c, load_c;
  logic          run_c, fall_stb_c, rise_stb_c;

  assign run_c = (state_q == ST_RUN);

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_c),
    .bclk       (i2s_bclk),
    .fall_stb_c (fall_stb_c),
    .rise_stb_c (rise_stb_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Stop requests are honoured only at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (fall_stb_c && (bit_cnt == LAST_BIT) && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit sequencing, shift-register stepping and frame-start load decision.
  always_comb begin
    bit_cnt_d     = bit_cnt;
    lrc_d         = i2s_lrc;
    dout_d        = i2s_dout;
    sh_l_d        = sh_l;
    sh_r_d        = sh_r;
    tx_done_d     = 1'b0;
    underrun_d    = 1'b0;
    frame_start_c = 1'b0;
    load_c        = 1'b0;
    pos_c         = '0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d     = '0;
        lrc_d         = 1'b0;
        dout_d        = 1'b0;
        frame_start_c = enable;
      end
      ST_RUN: begin
        if (fall_stb_c) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_d     = '0;
            lrc_d         = 1'b0;
            dout_d        = 1'b0;
            tx_done_d     = 1'b1;
            frame_start_c = enable;
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            lrc_d     = (bit_cnt_d >= SLOT_B);
            pos_c     = lrc_d ? (bit_cnt_d - SLOT_B) : bit_cnt_d;
            dout_d    = 1'b0;
            if ((pos_c != '0) && (pos_c <= WL_B)) begin
              if (lrc_d) begin
                dout_d = sh_r[WL-1];
                sh_r_d = sh_r << 1;
              end else begin
                dout_d = sh_l[WL-1];
                sh_l_d = sh_l << 1;
              end
            end
          end
        end
      end
      default: ;
    endcase
    if (frame_start_c) begin
      if (!s_ready) begin
        sh_l_d = buf_l;
        sh_r_d = buf_r;
        load_c = 1'b1;
      end else begin
        sh_l_d     = '0;
        sh_r_d     = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      i2s_lrc  <= 1'b0;
      i2s_dout <= 1'b0;
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      sh_l     <= '0;
      sh_r     <= '0;
    end else begin
      bit_cnt  <= bit_cnt_d;
      i2s_lrc  <= lrc_d;
      i2s_dout <= dout_d;
      tx_done  <= tx_done_d;
      underrun <= underrun_d;
      sh_l     <= sh_l_d;
      sh_r     <= sh_r_d;
    end
  end

  // One-entry holding buffer; s_ready doubles as its empty flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready <= 1'b1;
      buf_l   <= '0;
      buf_r   <= '0;
    end else if (s_valid && s_ready) begin
      s_ready <= 1'b0;
      buf_l   <= s_data_l;
      buf_r   <= s_data_r;
    end else if (load_c) begin
      s_ready <= 1'b1;
    end
  end

  a_rise_only_in_run : assert property (@(posedge clk) disable iff (!rst_n)
    rise_stb_c |-> (state_q == ST_RUN));

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx against a frame-timing model derived
// from clock counts since the last frame start.
module tb_i2s_master_tx;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned WL      = 24;
  localparam int unsigned SLOT    = 32;
  localparam int unsigned FRAME   = 4 * SLOT * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n, enable, s_valid, s_ready;
  logic [WL-1:0] s_data_l, s_data_r;
  logic          i2s_bclk, i2s_lrc, i2s_dout, tx_done, underrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_run, m_bfull, exp_done, exp_und, last_acc;
  int unsigned   m_t;
  logic [WL-1:0] m_bl, m_br, m_fl, m_fr;

  i2s_master_tx #(
    .CLK_DIV (CLK_DIV),
    .WL      (WL),
    .SLOT    (SLOT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data_l (s_data_l),
    .s_data_r (s_data_r),
    .i2s_bclk (i2s_bclk),
    .i2s_lrc  (i2s_lrc),
    .i2s_dout (i2s_dout),
    .tx_done  (tx_done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d run=%0d observed=%b expected=%b", tag, m_t, m_run, obs, exp);
    end
  endtask

  // Advance the model across one clk edge using the inputs currently driven,
  // then compare every output at the following falling edge.
  task automatic tick();
    bit            fs, acc, e_bclk, e_lrc, e_dout;
    int unsigned   b, p;
    logic [WL-1:0] w;
    fs       = 1'b0;
    exp_done = 1'b0;
    exp_und  = 1'b0;
    last_acc = 1'b0;
    acc      = s_valid && !m_bfull;
    if (!rst_n) begin
      m_run   = 1'b0;
      m_t     = 0;
      m_bfull = 1'b0;
    end else begin
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1;
          m_t   = 0;
          fs    = 1'b1;
        end
      end else if (m_t == FRAME - 1) begin
        exp_done = 1'b1;
        m_t      = 0;
        if (enable) fs = 1'b1;
        else        m_run = 1'b0;
      end else begin
        m_t++;
      end
      if (fs) begin
        if (m_bfull) begin
          m_fl    = m_bl;
          m_fr    = m_br;
          m_bfull = 1'b0;
        end else begin
          m_fl    = '0;
          m_fr    = '0;
          exp_und = 1'b1;
        end
      end
      if (acc) begin
        m_bfull  = 1'b1;
        m_bl     = s_data_l;
        m_br     = s_data_r;
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e_bclk = 1'b0;
    e_lrc  = 1'b0;
    e_dout = 1'b0;
    if (m_run) begin
      b      = m_t / (2 * CLK_DIV);
      p      = b % SLOT;
      e_bclk = ((m_t / CLK_DIV) % 2) == 1;
      e_lrc  = (b >= SLOT);
      w      = e_lrc ? m_fr : m_fl;
      if (p >= 1 && p <= WL) e_dout = w[WL-p];
    end
    check("bclk", i2s_bclk, e_bclk);
    check("lrc", i2s_lrc, e_lrc);
    check("dout", i2s_dout, e_dout);
    check("tx_done", tx_done, exp_done);
    check("underrun", underrun, exp_und);
    check("s_ready", s_ready, !m_bfull);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a sample and hold s_valid until the model sees it accepted.
  task automatic push_hold(input logic [WL-1:0] l, input logic [WL-1:0] r, input string tag);
    bit got;
    got      = 1'b0;
    s_valid  = 1'b1;
    s_data_l = l;
    s_data_r = r;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      got = last_acc;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s accept_timeout observed=0 expected=1", tag);
    end
  endtask

  task automatic wait_bit(input int unsigned t_target, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      got = m_run && (m_t == t_target);
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s position_timeout observed=0 expected=1", tag);
    end
  endtask

  initial begin
    m_run    = 1'b0;
    m_bfull  = 1'b0;
    m_t      = 0;
    m_bl     = '0;
    m_br     = '0;
    m_fl     = '0;
    m_fr     = '0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    s_valid  = 1'b0;
    s_data_l = '0;
    s_data_r = '0;
    @(negedge clk);

    // Reset state, then reset held with enable high
    ticks(2);
    enable = 1'b1;
    ticks(3);
    enable = 1'b0;
    rst_n  = 1'b1;
    ticks(2);

    // Fixed pattern frame, followed by two underrun frames
    s_valid  = 1'b1;
    s_data_l = 24'hA5A5A5;
    s_data_r = 24'h5A5A5A;
    tick();
    s_valid = 1'b0;
    tick();
    enable = 1'b1;
    ticks(3 * FRAME);

    // Back-pressure: second sample waits for the frame-start transfer
    ticks(17);
    push_hold(24'h000001, 24'($urandom), "bp_first");
    push_hold(24'h800000, 24'($urandom), "bp_second");
    for (int k = 0; k < 3; k++) push_hold(24'($urandom), 24'($urandom), "random_push");
    s_valid = 1'b0;
    ticks(2 * FRAME);

    // Stop request at bit 40: frame completes, then idle
    push_hold(24'($urandom), 24'($urandom), "pre_stop_push");
    s_valid = 1'b0;
    wait_bit(40 * 2 * CLK_DIV + 1, "stop_pos");
    enable = 1'b0;
    ticks(FRAME);

    // Reset at bit 10, then restart cleanly
    enable = 1'b1;
    s_valid  = 1'b1;
    s_data_l = 24'($urandom);
    s_data_r = 24'($urandom);
    tick();
    s_valid = 1'b0;
    wait_bit(10 * 2 * CLK_DIV + 1, "reset_pos");
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(FRAME + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
